video_out_adapter: RTL and testbench
====================================

Name: video_out_adapter

Overview:
- Parametrised successor to the ad-hoc video output stage in the core top levels. Converts a core's raw colour/blank/sync/pixel-enable outputs into the Pocket `video_if` signal set on the dot clock.
- Adds:
  - configurable colour depth with bit-replicated expansion;
  - sync polarity;
  - HS delay;
  - CE stretch length;
  - start-of-frame lock;
  - measured active width/height and a frame counter, for debug and bridge readback.

Parameters:
- COLOR_BITS, 4: bits per colour channel in, 1..8.
- CE_STRETCH, 2: number of samples OR-ed to form the held pixel enable, >=1.
- HS_POSITIVE, 1: 1 = hsync active high, 0 = active low.
- VS_POSITIVE, 1: 1 = vsync active high, 0 = active low.
- HS_DELAY, 3: extra clk cycles between the vs/edge timing and the hs pulse, >=0.
- COUNT_WIDTH, 12: width of the width/height/frame counters.

Ports:
- clk  in  1  dot clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- r_in, g_in, b_in  in  COLOR_BITS each  core colour.
- hblank, vblank  in  1 each  active-high blanking.
- hsync, vsync  in  1 each  raw sync, polarity per parameter.
- ce_pixel  in  1  core pixel enable.
- rgb  out  24  {R8,G8,B8}.
- de  out  1  data enable.
- skip  out  1  de cycle carrying no new pixel.
- hs, vs  out  1 each  single-cycle sync pulses.
- locked  out  1  first frame start seen.
- frame_width  out  COUNT_WIDTH  pixels (de & ~skip) in the last completed active line.
- frame_height  out  COUNT_WIDTH  active lines in the last completed frame.
- frame_count  out  COUNT_WIDTH  frame starts since reset, wrapping.

Behaviour:
- **Reset:** every output and internal register is 0 while reset_n is low. Reset may assert mid-frame; after release the block relocks from scratch.
- **Input stage:** all inputs are registered once (stage 1). A sync edge is an inactive-to-active transition between consecutive stage-1 samples, after polarity normalisation.
- **Latency:** rgb, de, skip and vs are valid 2 cycles after the input sample. hs follows the input hsync edge by 2+HS_DELAY cycles.
- **Colour:** 8-bit value = input repeated MSB-first and truncated to 8 bits.
  - 4-bit x gives {x,x}.
  - 5-bit x gives {x,x[4:2]}.
  - 8-bit passes through unchanged.
  - rgb = 0 whenever de = 0.
- **de:** ~(hblank | vblank).
- **ce_held:** OR of ce_pixel over the current and previous CE_STRETCH-1 stage-1 samples. skip = de & ~ce_held.
- **Lock state machine:**
  - UNLOCKED (reset state): de, skip, rgb, hs held 0. The first vsync edge emits a vs pulse, sets locked=1 and moves to LOCKED.
  - LOCKED: outputs pass through. Leaves only via reset.
- **vs / hs pulses:**
  - vs is exactly 1 cycle per vsync edge. Constant active vsync gives no further pulses.
  - hs is exactly 1 cycle per hsync edge, emitted only in LOCKED (the edge must be detected while LOCKED).
  - hs uses a delay line, so edges closer together than HS_DELAY still each produce a pulse.
- **Pixel counter:** increments on each output cycle with de & ~skip. On de falling it latches into frame_width and clears.
- **Line counter:** increments on each de falling. On a vsync edge it latches into frame_height and clears, and frame_count increments.
- **Saturation and wrap:** pixel and line counters saturate at all-ones. frame_count wraps to 0.
- **Simultaneous de falling and vsync edge:** the line is counted first, so frame_height includes it. frame_width latches in the same cycle.
- **Measurement gating:** counting runs only in LOCKED. Values from UNLOCKED are never latched.

Test Plan:
- **Lock:** reset, then 5 hsync edges with no vsync -> hs, de, rgb stay 0 and locked=0. A vsync edge -> one vs pulse 2 cycles later, locked=1, frame_count=1.
- **Colour expansion:** COLOR_BITS=4, R=0xA, G=0x3, B=0xF with de active -> rgb=0xAA33FF 2 cycles later. COLOR_BITS=5, R=0x13 -> R8=0x9C. Blanking -> rgb=0.
- **CE stretch:** 8 de cycles with ce_pixel alternating 1,0.
  - CE_STRETCH=1 -> skip on the 4 ce=0 cycles, frame_width=4.
  - CE_STRETCH=2 -> skip never set, frame_width=8.
- **Frame measurement:** 3 active lines then a vsync edge -> frame_height=3, frame_count increments. Also: last line's de falling coincident with the vsync edge -> frame_height=3.
- **HS delay:** HS_DELAY=3, hsync edges 2 cycles apart -> two 1-cycle hs pulses at input+5 and input+7. HS_POSITIVE=0 with hsync held low -> single pulse.
- **Reset mid-frame:** reset_n low mid-line -> all outputs 0 immediately (asynchronous). After release: locked=0, and the next vsync relocks with frame_count=1.

Source files
------------

// File: rtl/video_out_adapter.sv
// Core video output stage: registers raw colour/blank/sync/ce from the core and
// produces the Pocket video signal set with frame lock and active-area measurement.

module video_out_color_expand #(
    parameter int COLOR_BITS = 4
) (
    input  logic [COLOR_BITS-1:0] x,
    output logic [7:0]            y
);
    // Repeat the input MSB-first until 8 bits are filled.
    always_comb begin
        y = '0;
        for (int i = 0; i < 8; i++)
            y[7-i] = x[COLOR_BITS-1-(i % COLOR_BITS)];
    end
endmodule

module video_out_adapter #(
    parameter int COLOR_BITS  = 4,
    parameter int CE_STRETCH  = 2,
    parameter int HS_POSITIVE = 1,
    parameter int VS_POSITIVE = 1,
    parameter int HS_DELAY    = 3,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COLOR_BITS-1:0]  r_in,
    input  logic [COLOR_BITS-1:0]  g_in,
    input  logic [COLOR_BITS-1:0]  b_in,
    input  logic                   hblank,
    input  logic                   vblank,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   ce_pixel,
    output logic [23:0]            rgb,
    output logic                   de,
    output logic                   skip,
    output logic                   hs,
    output logic                   vs,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] frame_width,
    output logic [COUNT_WIDTH-1:0] frame_height,
    output logic [COUNT_WIDTH-1:0] frame_count
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t state, state_nxt;

    logic [2:0][COLOR_BITS-1:0] col_s1;
    logic [2:0][7:0]            col_x;
    logic                       hb_s1, vb_s1;
    logic                       hs_s1, vs_s1, hs_prev, vs_prev;
    logic [CE_STRETCH-1:0]      ce_sh;
    logic [HS_DELAY:0]          hs_pipe;
    logic [COUNT_WIDTH-1:0]     pix_cnt, line_cnt, line_nxt;

    logic hs_edge, vs_edge, is_locked, de_g, ce_held, pix, de_fall;

    // Stage 1: sync levels are stored already normalised to active-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_s1  <= '0;
            hb_s1   <= 1'b0;
            vb_s1   <= 1'b0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            ce_sh   <= '0;
        end else begin
            col_s1  <= {r_in, g_in, b_in};
            hb_s1   <= hblank;
            vb_s1   <= vblank;
            hs_s1   <= (HS_POSITIVE != 0) ? hsync : ~hsync;
            vs_s1   <= (VS_POSITIVE != 0) ? vsync : ~vsync;
            hs_prev <= hs_s1;
            vs_prev <= vs_s1;
            ce_sh   <= (ce_sh << 1) | CE_STRETCH'(ce_pixel);
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        video_out_color_expand #(.COLOR_BITS(COLOR_BITS)) u_exp (
            .x (col_s1[ch]),
            .y (col_x[ch])
        );
    end

    assign hs_edge   = hs_s1 & ~hs_prev;
    assign vs_edge   = vs_s1 & ~vs_prev;
    assign is_locked = (state == LOCKED);
    assign de_g      = ~(hb_s1 | vb_s1) & is_locked;
    assign ce_held   = |ce_sh;
    assign pix       = de_g & ce_held;
    // The registered de is the previous gated sample, so this marks the line end.
    assign de_fall   = de & ~de_g;
    assign line_nxt  = (de_fall && line_cnt != '1) ? line_cnt + COUNT_WIDTH'(1) : line_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= UNLOCKED;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (vs_edge) state_nxt = LOCKED;
            LOCKED:   state_nxt = LOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb     <= '0;
            de      <= 1'b0;
            skip    <= 1'b0;
            vs      <= 1'b0;
            hs_pipe <= '0;
        end else begin
            rgb     <= de_g ? col_x : 24'h0;
            de      <= de_g;
            skip    <= de_g & ~ce_held;
            vs      <= vs_edge;
            hs_pipe <= (hs_pipe << 1) | (HS_DELAY+1)'(hs_edge & is_locked);
        end
    end

    assign hs     = hs_pipe[HS_DELAY];
    assign locked = is_locked;

    // A de falling coincident with a vsync edge is folded into line_nxt first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            frame_width  <= '0;
            frame_height <= '0;
            frame_count  <= '0;
        end else begin
            if (vs_edge)
                frame_count <= frame_count + COUNT_WIDTH'(1);
            if (is_locked) begin
                if (de_fall) begin
                    frame_width <= pix_cnt;
                    pix_cnt     <= '0;
                end else if (pix && pix_cnt != '1) begin
                    pix_cnt <= pix_cnt + COUNT_WIDTH'(1);
                end
                if (vs_edge) begin
                    frame_height <= line_nxt;
                    line_cnt     <= '0;
                end else begin
                    line_cnt <= line_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_out_adapter.sv
// Directed bench for video_out_adapter: two instances (4-bit/CE2/positive and
// 5-bit/CE1/negative-hsync) share blank, vsync and ce stimulus.
module tb_video_out_adapter;
    logic clk = 1'b0;
    logic reset_n;
    logic hb, vb, vsy, ce, hsa, hsb;
    logic [3:0] a_r, a_g, a_b;
    logic [4:0] b_r, b_g, b_b;

    logic [23:0] a_rgb, b_rgb;
    logic a_de, a_skip, a_hs, a_vs, a_locked;
    logic b_de, b_skip, b_hs, b_vs, b_locked;
    logic [11:0] a_fw, a_fh, a_fc, b_fw, b_fh, b_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_out_adapter #(.COLOR_BITS(4), .CE_STRETCH(2), .HS_POSITIVE(1),
                        .VS_POSITIVE(1), .HS_DELAY(3), .COUNT_WIDTH(12)) dut_a (
        .clk(clk), .reset_n(reset_n), .r_in(a_r), .g_in(a_g), .b_in(a_b),
        .hblank(hb), .vblank(vb), .hsync(hsa), .vsync(vsy), .ce_pixel(ce),
        .rgb(a_rgb), .de(a_de), .skip(a_skip), .hs(a_hs), .vs(a_vs),
        .locked(a_locked), .frame_width(a_fw), .frame_height(a_fh), .frame_count(a_fc));

    video_out_adapter #(.COLOR_BITS(5), .CE_STRETCH(1), .HS_POSITIVE(0),
                        .VS_POSITIVE(1), .HS_DELAY(3), .COUNT_WIDTH(12)) dut_b (
        .clk(clk), .reset_n(reset_n), .r_in(b_r), .g_in(b_g), .b_in(b_b),
        .hblank(hb), .vblank(vb), .hsync(hsb), .vsync(vsy), .ce_pixel(ce),
        .rgb(b_rgb), .de(b_de), .skip(b_skip), .hs(b_hs), .vs(b_vs),
        .locked(b_locked), .frame_width(b_fw), .frame_height(b_fh), .frame_count(b_fc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int n);
        hb = 1'b0;
        repeat (n) tick();
        hb = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        hb = 1'b1; vb = 1'b1; vsy = 1'b0; ce = 1'b1; hsa = 1'b0; hsb = 1'b1;
        a_r = 4'h0; a_g = 4'h0; a_b = 4'h0;
        b_r = 5'h0; b_g = 5'h0; b_b = 5'h0;
        tick(); tick();
        chk("reset_a", 80'({a_rgb, a_de, a_skip, a_hs, a_vs, a_locked, a_fw, a_fh, a_fc}), 80'(0));
        chk("reset_b", 80'({b_rgb, b_de, b_skip, b_hs, b_vs, b_locked, b_fw, b_fh, b_fc}), 80'(0));
        reset_n = 1'b1;

        // Unlocked: five hsync edges with active video, everything stays quiet.
        hb = 1'b0; vb = 1'b0; a_r = 4'hA; a_g = 4'h3; a_b = 4'hF;
        for (int i = 0; i < 16; i++) begin
            hsa = (i < 10) && (i % 2 == 1);
            tick();
            chk("unlocked_out", 80'({a_de, a_hs, a_rgb, a_locked, a_skip, b_hs}), 80'(0));
        end
        chk("unlocked_fc", 80'(a_fc), 80'(0));

        // Lock on first vsync edge.
        hb = 1'b1; vb = 1'b1; hsa = 1'b0;
        repeat (3) tick();
        vsy = 1'b1;
        tick();
        chk("vs_early", 80'(a_vs), 80'(0));
        tick();
        chk("lock_vs", 80'({a_vs, a_locked, b_vs, b_locked}), 80'(4'hF));
        chk("lock_fc", 80'(a_fc), 80'(1));
        tick();
        chk("vs_single", 80'(a_vs), 80'(0));
        repeat (3) tick();
        chk("vs_held", 80'(a_vs), 80'(0));
        vsy = 1'b0;
        tick(); tick();

        // Colour expansion.
        vb = 1'b0; hb = 1'b0;
        b_r = 5'h13; b_g = 5'h00; b_b = 5'h00;
        tick(); tick();
        chk("rgb4", 80'({a_de, a_rgb}), 80'({1'b1, 24'hAA33FF}));
        chk("rgb5", 80'(b_rgb), 80'(24'h9C0000));
        hb = 1'b1;
        tick(); tick();
        chk("rgb_blank", 80'({a_de, a_rgb, b_rgb}), 80'(0));
        repeat (3) tick();

        // CE stretch: 8 active cycles with ce alternating 1,0.
        for (int i = 0; i < 10; i++) begin
            hb = (i >= 8);
            ce = (i >= 8) ? 1'b1 : (i % 2 == 0);
            tick();
            if (i >= 1 && i <= 8) begin
                chk("skip_ce2", 80'(a_skip), 80'(0));
                chk("skip_ce1", 80'(b_skip), 80'((i - 1) % 2 == 1));
            end
        end
        tick(); tick();
        chk("width_ce2", 80'(a_fw), 80'(8));
        chk("width_ce1", 80'(b_fw), 80'(4));

        // Frame measurement: clear with a vsync, then 3 lines and a vsync.
        vsy = 1'b1; tick(); vsy = 1'b0; tick();
        repeat (3) tick();
        line(5); line(5); line(5);
        vsy = 1'b1; tick(); vsy = 1'b0; tick();
        repeat (3) tick();
        chk("height3", 80'({a_fh, b_fh}), 80'({12'd3, 12'd3}));
        chk("fcount3", 80'({a_fc, b_fc}), 80'({12'd3, 12'd3}));
        chk("width5", 80'({a_fw, b_fw}), 80'({12'd5, 12'd5}));

        // Last de falling on the same stage-1 cycle as the vsync edge.
        line(5); line(5);
        hb = 1'b0;
        repeat (5) tick();
        hb = 1'b1; vsy = 1'b1;
        tick();
        vsy = 1'b0;
        tick();
        repeat (3) tick();
        chk("height_coinc", 80'(a_fh), 80'(3));
        chk("fcount_coinc", 80'(a_fc), 80'(4));
        chk("width_coinc", 80'(a_fw), 80'(5));

        // HS delay: A gets edges 2 apart; B gets a held active-low hsync.
        for (int i = 0; i < 10; i++) begin
            hsa = (i == 0 || i == 2);
            hsb = 1'b0;
            tick();
            chk("hs_delay_a", 80'(a_hs), 80'(i == 4 || i == 6));
            chk("hs_neg_b", 80'(b_hs), 80'(i == 4));
        end
        hsa = 1'b0; hsb = 1'b1;
        repeat (6) tick();

        // Asynchronous reset in the middle of a line.
        hb = 1'b0;
        repeat (3) tick();
        chk("pre_reset_de", 80'(a_de), 80'(1));
        reset_n = 1'b0;
        #1;
        chk("async_reset_a", 80'({a_rgb, a_de, a_skip, a_hs, a_vs, a_locked, a_fw, a_fh, a_fc}), 80'(0));
        chk("async_reset_b", 80'({b_locked, b_fc}), 80'(0));
        tick(); tick();
        reset_n = 1'b1; hb = 1'b1;
        repeat (3) tick();
        chk("post_reset", 80'({a_locked, a_fc}), 80'(0));
        vsy = 1'b1; tick(); vsy = 1'b0; tick();
        chk("relock", 80'({a_vs, a_locked, a_fc}), 80'({1'b1, 1'b1, 12'd1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
